// File: rtl/serial_sub32_if.sv
// Operand/result bundle between a datapath controller (master) and serial_sub32 (slave).
// The ovf signal exists only when OVERFLOW_FLAG_EN is defined.
interface serial_sub32_if #(
  parameter int WIDTH = 32
);
  // start is a request sampled only while the subtractor is idle or done; a/b/bin
  // are captured on the accepting edge, busy covers the slice cycles and done is
  // a one-cycle pulse marking d/bout (and ovf) valid.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, d, bout);
  modport slave  (input start, a, b, bin, output busy, done, d, bout);
`endif
endinterface

// File: rtl/serial_sub32.sv
// Multi-cycle subtractor d = a - b - bin, one SLICE-bit slice per clock, LSB first.
// Define OVERFLOW_FLAG_EN to add a registered signed-overflow flag (ovf).
module serial_sub32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub32_if.slave bus,
  output logic [1:0]   state_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic [IW-1:0]    base;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   diff;
  logic [WIDTH-1:0] part_d;
  logic             last;

  // One extra bit on the slice difference: it goes negative exactly when a borrow is needed.
  always_comb begin
    base   = IW'(cnt_q) * IW'(SLICE);
    a_sl   = a_q[base +: SLICE];
    b_sl   = b_q[base +: SLICE];
    diff   = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, borrow_q};
    part_d = part_q;
    part_d[base +: SLICE] = diff[SLICE-1:0];
    last   = (cnt_q == CW'(NSLICE - 1));
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;
  logic ovf_d;
  assign ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.bin;
            part_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          part_q   <= part_d;
          borrow_q <= diff[SLICE];
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            d_q     <= part_d;
            bout_q  <= diff[SLICE];
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_serial_sub32.sv
// Directed-vector bench for serial_sub32: table of hand-computed results, protocol and
// reset corner cases, then random operands against a behavioural a - b - bin model.
module tb_serial_sub32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_o;

  serial_sub32_if #(.WIDTH(32)) sif ();

  serial_sub32 #(.WIDTH(32), .SLICE(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (sif),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Expected {ovf, bout, d} per launched operation.
  logic [33:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] exp_d;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic bin);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = a;
    sif.b     = b;
    sif.bin   = bin;
    @(negedge clk);
    sif.start = 1'b0;
    sif.a     = $urandom;
    sif.b     = $urandom;
    sif.bin   = 1'($urandom_range(0, 1));
  endtask

  // Called at the first negedge after the capturing edge; returns at the done negedge.
  task automatic wait_done(input string tag, input logic [31:0] hold_d, input bit poke);
    int n     = 0;
    int guard = 0;
    bit held  = 1'b1;
    while (sif.done !== 1'b1 && guard < 40) begin
      if (sif.busy === 1'b1) n++;
      if (sif.d !== hold_d) held = 1'b0;
      if (poke) begin
        sif.start = guard[0];
        sif.a     = $urandom;
        sif.b     = $urandom;
      end
      guard++;
      @(negedge clk);
    end
    sif.start = 1'b0;
    check({tag, " done_seen"}, 33'(sif.done), 33'(1));
    check({tag, " busy_cycles"}, 33'(n), 33'(8));
    check({tag, " d_held_in_run"}, 33'(held), 33'(1));
    check({tag, " busy_at_done"}, 33'(sif.busy), 33'(0));
  endtask

  task automatic check_result(input string tag);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " exp_q_empty"}, 33'(0), 33'(1));
      return;
    end
    e = exp_q.pop_front();
    check({tag, " d"}, 33'(sif.d), 33'(e[31:0]));
    check({tag, " bout"}, 33'(sif.bout), 33'(e[32]));
`ifdef OVERFLOW_FLAG_EN
    check({tag, " ovf"}, 33'(sif.ovf), 33'(e[33]));
`endif
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic [31:0] ed, input logic eb, input logic eo);
    logic [31:0] prev;
    prev = sif.d;
    exp_q.push_back({eo, eb, ed});
    launch(a, b, bin);
    wait_done(tag, prev, 1'b0);
    check_result(tag);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 33'({sif.done, sif.busy}), 33'(0));
  endtask

  initial begin
    logic [32:0] r;
    logic        eo;
    bit          done_seen;

    vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFE, 1'b0, 1'b1};
    vecs[3]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0};
    vecs[8]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[9]  = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 32'h1E1E_1E1F, 1'b1, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};

    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    sif.bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {sif.busy, sif.done, sif.bout, sif.d[29:0]}, 33'(0));
    check("reset d", 33'(sif.d), 33'(0));
    check("reset state", 33'(state_o), 33'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle outputs", 33'({sif.busy, sif.done, sif.bout}), 33'(0));

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].exp_d, vecs[i].exp_bout, vecs[i].exp_ovf);

    // Asynchronous clear between edges: the last vector left d nonzero.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset d", 33'(sif.d), 33'(0));
    check("async reset flags", 33'({sif.busy, sif.done, sif.bout}), 33'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: start held during the DONE cycle, then junk starts while busy.
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0002});
    launch(32'h5, 32'h3, 1'b0);
    wait_done("b2b1", 32'h0, 1'b0);
    check_result("b2b1");
    exp_q.push_back({1'b0, 1'b1, 32'hFFFF_FFFF});
    sif.start = 1'b1;
    sif.a     = 32'h1234_5678;
    sif.b     = 32'h1234_5678;
    sif.bin   = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    check("b2b no idle state", 33'(state_o), 33'(1));
    wait_done("b2b2", 32'h0000_0002, 1'b1);
    check_result("b2b2");
    @(negedge clk);
    check("b2b2 done_one_cycle", 33'({sif.done, sif.busy}), 33'(0));

    // Reset while slice 4 is being processed.
    launch(32'hFFFF_FFFF, 32'h1, 1'b0);
    repeat (4) @(negedge clk);
    check("midop busy before reset", 33'(sif.busy), 33'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midop reset d", 33'(sif.d), 33'(0));
    check("midop reset flags", 33'({sif.busy, sif.done, sif.bout}), 33'(0));
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (sif.done === 1'b1) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (sif.done === 1'b1) done_seen = 1'b1;
    end
    check("midop no done", 33'(done_seen), 33'(0));
    check("midop idle busy", 33'(sif.busy), 33'(0));
    run_op("after_abort", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      logic        rbin;
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = ra;
      r  = {1'b0, ra} - {1'b0, rb} - {32'b0, rbin};
      eo = (ra[31] != rb[31]) && (r[31] != ra[31]);
      run_op($sformatf("rnd%0d", i), ra, rb, rbin, r[31:0], r[32], eo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
